// File: rtl/tim_pkg.sv
// Shared timer definitions: output-compare modes, default widths and the pin-pair type.
package tim_pkg;

  localparam int CNT_WIDTH_DEF = 16;
  localparam int DT_WIDTH_DEF  = 8;

  typedef enum logic [2:0] {
    OCM_FROZEN   = 3'b000,
    OCM_ACT      = 3'b001,
    OCM_INACT    = 3'b010,
    OCM_TOGGLE   = 3'b011,
    OCM_FORCE_LO = 3'b100,
    OCM_FORCE_HI = 3'b101,
    OCM_PWM1     = 3'b110,
    OCM_PWM2     = 3'b111
  } ocm_e;

  typedef struct packed {
    logic oc;
    logic ocn;
  } oc_pair_t;

endpackage

// File: rtl/tim_deadtime.sv
// Dead-time insertion: delays rising edges of ref (OCx) and ~ref (OCxN) by dtg_i cycles.
// Outputs are combinational; the channel's output register adds the single pipeline stage.
module tim_deadtime #(
  parameter int DT_WIDTH = 8
) (
  input  logic                clk_i,
  input  logic                aresetn_i,
  input  logic                ref_i,
  input  logic [DT_WIDTH-1:0] dtg_i,
  output logic                oc_o,
  output logic                ocn_o
);

  logic [1:0] lvl;
  logic [1:0] out;

  assign lvl = {~ref_i, ref_i};

  for (genvar p = 0; p < 2; p++) begin : g_path
    logic                lvl_q;
    logic [DT_WIDTH-1:0] cnt_q;
    logic                rise;

    assign rise = lvl[p] & ~lvl_q;
    // The rise cycle itself counts as the first blocked cycle, so the counter
    // holds the remaining dtg_i-1 blocked cycles.
    assign out[p] = lvl[p] & (cnt_q == '0) & ~(rise & (dtg_i != '0));

    always_ff @(posedge clk_i) begin
      if (!aresetn_i) begin
        lvl_q <= 1'b0;
        cnt_q <= '0;
      end else begin
        lvl_q <= lvl[p];
        if (rise)
          cnt_q <= (dtg_i == '0) ? '0 : dtg_i - 1'b1;
        else if (lvl[p] != lvl_q)
          cnt_q <= '0;
        else if (cnt_q != '0)
          cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  assign oc_o  = out[0];
  assign ocn_o = out[1];

endmodule

// File: rtl/tim_oc_channel.sv
// Timer output-compare / PWM channel: preloadable CCR, compare, OCxREF mode logic,
// clear latch, dead time and polarity/enable gating of the complementary pins.
module tim_oc_channel #(
  parameter int CNT_WIDTH = tim_pkg::CNT_WIDTH_DEF,
  parameter int DT_WIDTH  = tim_pkg::DT_WIDTH_DEF
) (
  input  logic                 clk_i,
  input  logic                 aresetn_i,
  input  logic [CNT_WIDTH-1:0] cnt_i,
  input  logic                 cnt_dir_i,
  input  logic                 uev_i,
  input  logic [CNT_WIDTH-1:0] ccr_wdata_i,
  input  logic                 ccr_we_i,
  input  logic                 ocpe_i,
  input  logic [2:0]           ocm_i,
  input  logic                 occe_i,
  input  logic                 ocref_clr_i,
  input  logic                 cce_i,
  input  logic                 ccne_i,
  input  logic                 ccp_i,
  input  logic                 ccnp_i,
  input  logic [DT_WIDTH-1:0]  dtg_i,
  output logic                 ocref_o,
  output logic                 oc_o,
  output logic                 ocn_o,
  output logic                 ccif_o,
  output logic [CNT_WIDTH-1:0] ccr_o
);
  import tim_pkg::*;

  ocm_e                 ocm;
  logic [CNT_WIDTH-1:0] ccr_shadow_q, ccr_active_q;
  logic                 match, pwm1;
  logic                 clr_req, clr_lat_q;
  logic                 ref_q, ref_nxt;
  logic                 ccif_q;
  logic                 dt_oc, dt_ocn;
  oc_pair_t             pin_q;

  assign ocm = ocm_e'(ocm_i);

  // A write coinciding with a preloaded update goes straight to the active register.
  always_ff @(posedge clk_i) begin
    if (!aresetn_i) begin
      ccr_shadow_q <= '0;
      ccr_active_q <= '0;
    end else begin
      if (ccr_we_i)
        ccr_shadow_q <= ccr_wdata_i;
      if (ccr_we_i && (!ocpe_i || uev_i))
        ccr_active_q <= ccr_wdata_i;
      else if (ocpe_i && uev_i)
        ccr_active_q <= ccr_shadow_q;
    end
  end

  assign match   = (cnt_i == ccr_active_q);
  assign pwm1    = cnt_dir_i ? (cnt_i <= ccr_active_q) : (cnt_i < ccr_active_q);
  assign clr_req = ocref_clr_i & occe_i;

  always_comb begin
    ref_nxt = ref_q;
    unique case (ocm)
      OCM_FROZEN:   ref_nxt = ref_q;
      OCM_ACT:      ref_nxt = match ? 1'b1 : ref_q;
      OCM_INACT:    ref_nxt = match ? 1'b0 : ref_q;
      OCM_TOGGLE:   ref_nxt = match ? ~ref_q : ref_q;
      OCM_FORCE_LO: ref_nxt = 1'b0;
      OCM_FORCE_HI: ref_nxt = 1'b1;
      OCM_PWM1:     ref_nxt = pwm1;
      OCM_PWM2:     ref_nxt = ~pwm1;
      default:      ref_nxt = ref_q;
    endcase
    if (clr_req || clr_lat_q)
      ref_nxt = 1'b0;
  end

  // Set beats release when a clear request lands on an update event.
  always_ff @(posedge clk_i) begin
    if (!aresetn_i) begin
      clr_lat_q <= 1'b0;
      ref_q     <= 1'b0;
      ccif_q    <= 1'b0;
    end else begin
      if (clr_req)
        clr_lat_q <= 1'b1;
      else if (uev_i)
        clr_lat_q <= 1'b0;
      ref_q  <= ref_nxt;
      ccif_q <= match;
    end
  end

  tim_deadtime #(
    .DT_WIDTH (DT_WIDTH)
  ) u_deadtime (
    .clk_i     (clk_i),
    .aresetn_i (aresetn_i),
    .ref_i     (ref_q),
    .dtg_i     (dtg_i),
    .oc_o      (dt_oc),
    .ocn_o     (dt_ocn)
  );

  always_ff @(posedge clk_i) begin
    if (!aresetn_i) begin
      pin_q <= '0;
    end else begin
      pin_q.oc  <= cce_i  ? (dt_oc  ^ ccp_i)  : 1'b0;
      pin_q.ocn <= ccne_i ? (dt_ocn ^ ccnp_i) : 1'b0;
    end
  end

  assign ocref_o = ref_q;
  assign ccif_o  = ccif_q;
  assign ccr_o   = ccr_active_q;
  assign oc_o    = pin_q.oc;
  assign ocn_o   = pin_q.ocn;

endmodule

// File: tb/tb_tim_oc_channel.sv
// Directed bench for tim_oc_channel: preload, PWM, toggle/freeze, dead time, clear, polarity, reset.
module tb_tim_oc_channel;

  logic        clk_i = 1'b0;
  logic        aresetn_i;
  logic [15:0] cnt_i;
  logic        cnt_dir_i, uev_i;
  logic [15:0] ccr_wdata_i;
  logic        ccr_we_i, ocpe_i;
  logic [2:0]  ocm_i;
  logic        occe_i, ocref_clr_i;
  logic        cce_i, ccne_i, ccp_i, ccnp_i;
  logic [7:0]  dtg_i;
  logic        ocref_o, oc_o, ocn_o, ccif_o;
  logic [15:0] ccr_o;

  int n_chk  = 0;
  int n_fail = 0;
  int hi_oc, hi_ocn, lo_both, hi_ref, bad;
  logic [9:0] pwm1_c3;
  logic       e;

  always #5 clk_i = ~clk_i;

  tim_oc_channel dut (
    .clk_i       (clk_i),
    .aresetn_i   (aresetn_i),
    .cnt_i       (cnt_i),
    .cnt_dir_i   (cnt_dir_i),
    .uev_i       (uev_i),
    .ccr_wdata_i (ccr_wdata_i),
    .ccr_we_i    (ccr_we_i),
    .ocpe_i      (ocpe_i),
    .ocm_i       (ocm_i),
    .occe_i      (occe_i),
    .ocref_clr_i (ocref_clr_i),
    .cce_i       (cce_i),
    .ccne_i      (ccne_i),
    .ccp_i       (ccp_i),
    .ccnp_i      (ccnp_i),
    .dtg_i       (dtg_i),
    .ocref_o     (ocref_o),
    .oc_o        (oc_o),
    .ocn_o       (ocn_o),
    .ccif_o      (ccif_o),
    .ccr_o       (ccr_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr_ccr(input logic [15:0] v);
    ccr_wdata_i = v;
    ccr_we_i    = 1'b1;
    tick();
    ccr_we_i    = 1'b0;
  endtask

  initial begin
    aresetn_i = 1'b0; cnt_i = 16'd100; cnt_dir_i = 1'b0; uev_i = 1'b0;
    ccr_wdata_i = '0; ccr_we_i = 1'b0; ocpe_i = 1'b0; ocm_i = 3'b000;
    occe_i = 1'b0; ocref_clr_i = 1'b0; cce_i = 1'b0; ccne_i = 1'b0;
    ccp_i = 1'b0; ccnp_i = 1'b0; dtg_i = 8'd0;
    pwm1_c3 = 10'b0000000111;

    // reset state
    tick(); tick();
    chk("rst_ocref", 32'(ocref_o), 0);
    chk("rst_oc",    32'(oc_o),    0);
    chk("rst_ocn",   32'(ocn_o),   0);
    chk("rst_ccif",  32'(ccif_o),  0);
    chk("rst_ccr",   32'(ccr_o),   0);
    aresetn_i = 1'b1;
    tick();

    // preload: shadow only until the update event
    ocpe_i = 1'b1;
    wr_ccr(16'd5);
    chk("pre_after_wr", 32'(ccr_o), 0);
    for (int i = 0; i < 9; i++) tick();
    chk("pre_before_uev", 32'(ccr_o), 0);
    uev_i = 1'b1; tick(); uev_i = 1'b0;
    chk("pre_after_uev", 32'(ccr_o), 5);
    ocpe_i = 1'b0;
    wr_ccr(16'd7);
    chk("direct_wr", 32'(ccr_o), 7);

    // PWM1 up-counting, CCR=3, period 10
    ocm_i = 3'b110;
    wr_ccr(16'd3);
    for (int i = 0; i < 20; i++) begin
      cnt_i = 16'(i % 10);
      tick();
      e = pwm1_c3[i % 10];
      chk("pwm1_ref", 32'(ocref_o), 32'(e));
      chk("pwm1_ccif", 32'(ccif_o), ((i % 10) == 3) ? 1 : 0);
    end
    cnt_dir_i = 1'b1;
    cnt_i = 16'd3; tick(); chk("pwm1_dn_eq", 32'(ocref_o), 1);
    cnt_i = 16'd4; tick(); chk("pwm1_dn_gt", 32'(ocref_o), 0);
    cnt_dir_i = 1'b0;

    // CCR=0 gives constant 0; CCR=all-ones is high except at max
    wr_ccr(16'd0);
    hi_ref = 0;
    for (int i = 0; i < 10; i++) begin
      cnt_i = 16'(i); tick();
      hi_ref += int'(ocref_o);
    end
    chk("pwm1_ccr0", 32'(hi_ref), 0);
    wr_ccr(16'hffff);
    cnt_i = 16'hffff; tick(); chk("pwm1_max_at_max", 32'(ocref_o), 0);
    cnt_i = 16'hfffe; tick(); chk("pwm1_max_below", 32'(ocref_o), 1);

    // toggle, CCR=4, period 8
    ocm_i = 3'b100; cnt_i = 16'd0;
    wr_ccr(16'd4);
    chk("force_lo", 32'(ocref_o), 0);
    ocm_i = 3'b011;
    for (int i = 0; i < 24; i++) begin
      cnt_i = 16'(i % 8); tick();
      chk("toggle", 32'(ocref_o), 32'(((i + 4) / 8) % 2));
    end
    ocm_i = 3'b000;
    for (int i = 0; i < 8; i++) begin
      cnt_i = 16'(i); tick();
      chk("frozen", 32'(ocref_o), 1);
    end
    ocm_i = 3'b011; cnt_i = 16'd4; tick();
    chk("toggle_resume", 32'(ocref_o), 0);

    // dead time, PWM1 CCR=6 period 12
    ocm_i = 3'b110; cce_i = 1'b1; ccne_i = 1'b1; dtg_i = 8'd2;
    wr_ccr(16'd6);
    hi_oc = 0; hi_ocn = 0; lo_both = 0;
    for (int i = 0; i < 48; i++) begin
      cnt_i = 16'(i % 12); tick();
      if (i >= 24) begin
        hi_oc   += int'(oc_o);
        hi_ocn  += int'(ocn_o);
        lo_both += int'(!oc_o && !ocn_o);
      end
    end
    chk("dt2_oc_high",  32'(hi_oc),   8);
    chk("dt2_ocn_high", 32'(hi_ocn),  8);
    chk("dt2_both_low", 32'(lo_both), 8);

    dtg_i = 8'd7;
    hi_oc = 0; hi_ocn = 0;
    for (int i = 0; i < 48; i++) begin
      cnt_i = 16'(i % 12); tick();
      if (i >= 24) begin
        hi_oc  += int'(oc_o);
        hi_ocn += int'(ocn_o);
      end
    end
    chk("dt7_oc_absorbed",  32'(hi_oc),  0);
    chk("dt7_ocn_absorbed", 32'(hi_ocn), 0);

    dtg_i = 8'd0;
    for (int i = 0; i < 36; i++) begin
      cnt_i = 16'(i % 12); tick();
      if (i >= 24) begin
        chk("dt0_oc",  32'(oc_o),  (((i - 1) % 12) < 6) ? 1 : 0);
        chk("dt0_ocn", 32'(ocn_o), (((i - 1) % 12) < 6) ? 0 : 1);
      end
    end

    // clear latch
    occe_i = 1'b1;
    cnt_i = 16'd0; tick(); chk("clr_pre", 32'(ocref_o), 1);
    cnt_i = 16'd1; ocref_clr_i = 1'b1; tick(); ocref_clr_i = 1'b0;
    chk("clr_now", 32'(ocref_o), 0);
    hi_ref = 0;
    for (int i = 2; i < 24; i++) begin
      cnt_i = 16'(i % 12); tick();
      hi_ref += int'(ocref_o);
    end
    chk("clr_held", 32'(hi_ref), 0);
    cnt_i = 16'd0; uev_i = 1'b1; tick(); uev_i = 1'b0;
    chk("clr_uev_cycle", 32'(ocref_o), 0);
    hi_ref = 0;
    for (int i = 0; i < 12; i++) begin
      cnt_i = 16'(i); tick();
      hi_ref += int'(ocref_o);
    end
    chk("clr_released", 32'(hi_ref), 6);
    occe_i = 1'b0;
    cnt_i = 16'd1; ocref_clr_i = 1'b1; tick(); ocref_clr_i = 1'b0;
    chk("clr_disabled", 32'(ocref_o), 1);
    hi_ref = 0;
    for (int i = 2; i < 14; i++) begin
      cnt_i = 16'(i % 12); tick();
      hi_ref += int'(ocref_o);
    end
    chk("clr_disabled_run", 32'(hi_ref), 6);

    // polarity and enable
    ccp_i = 1'b1; bad = 0;
    for (int i = 0; i < 24; i++) begin
      cnt_i = 16'(i % 12); tick();
      if (i >= 1) begin
        e = !(((i - 1) % 12) < 6);
        bad += int'(oc_o !== e);
        bad += int'(ocn_o !== e);
      end
    end
    chk("pol_mismatches", 32'(bad), 0);
    ccp_i = 1'b0; cce_i = 1'b0;
    hi_oc = 0; hi_ocn = 0;
    for (int i = 0; i < 12; i++) begin
      cnt_i = 16'(i); tick();
      hi_oc  += int'(oc_o);
      hi_ocn += int'(ocn_o);
    end
    chk("cce_off_oc", 32'(hi_oc), 0);
    chk("cce_off_ocn_runs", 32'(hi_ocn), 6);

    // reset mid-PWM
    cce_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cnt_i = 16'(i); tick();
    end
    chk("prerst_oc", 32'(oc_o), 1);
    cnt_i = 16'd2; aresetn_i = 1'b0; tick();
    chk("midrst_ocref", 32'(ocref_o), 0);
    chk("midrst_oc",    32'(oc_o),    0);
    chk("midrst_ocn",   32'(ocn_o),   0);
    chk("midrst_ccif",  32'(ccif_o),  0);
    chk("midrst_ccr",   32'(ccr_o),   0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
